// File: rtl/hp_class_sched_pkg.sv
// Shared constants for the binary16 classification scheduler: class bit
// positions, FSM encoding and binary16 field positions.
package hp_pkg;

  localparam int CLS_SNAN      = 5;
  localparam int CLS_QNAN      = 4;
  localparam int CLS_INF       = 3;
  localparam int CLS_ZERO      = 2;
  localparam int CLS_SUBNORMAL = 1;
  localparam int CLS_NORMAL    = 0;
  localparam int CLS_W         = 6;

  typedef logic [CLS_W-1:0] cls_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int FP_W      = 16;
  localparam int SIGN_BIT  = 15;
  localparam int EXP_MSB   = 14;
  localparam int EXP_LSB   = 10;
  localparam int SIG_MSB   = 9;
  localparam int SIG_LSB   = 0;
  localparam int QUIET_BIT = 9;

endpackage

// File: rtl/hp_class_sched_if.sv
// Requester/response bundle between the requesters, the consumer and the scheduler.
interface hp_class_sched_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [5:0]         rsp_class;
  logic               rsp_sign;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_class, rsp_sign
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_class, rsp_sign
  );
endinterface

// File: rtl/hp_classify.sv
// Combinational binary16 classifier producing a one-hot class vector.
module hp_classify
  import hp_pkg::*;
(
  input  logic [FP_W-1:0] f,
  output cls_t            cls
);

  logic [EXP_MSB-EXP_LSB:0] exp_f;
  logic [SIG_MSB-SIG_LSB:0] sig_f;
  logic                     unused_sign;

  assign exp_f       = f[EXP_MSB:EXP_LSB];
  assign sig_f       = f[SIG_MSB:SIG_LSB];
  assign unused_sign = f[SIGN_BIT];

  always_comb begin
    cls = '0;
    if (&exp_f) begin
      if (sig_f == '0)      cls[CLS_INF]  = 1'b1;
      else if (f[QUIET_BIT]) cls[CLS_QNAN] = 1'b1;
      else                  cls[CLS_SNAN] = 1'b1;
    end else if (exp_f == '0) begin
      if (sig_f == '0) cls[CLS_ZERO]      = 1'b1;
      else             cls[CLS_SUBNORMAL] = 1'b1;
    end else begin
      cls[CLS_NORMAL] = 1'b1;
    end
  end

endmodule

// File: rtl/hp_class_sched.sv
// Round-robin scheduler sharing one binary16 classifier among NREQ requesters,
// with a saturating count of delivered signalling-NaN results.
module hp_class_sched
  import hp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hp_class_sched_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] snan_cnt
);

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic [FP_W-1:0] op_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] rsp_id_q;
  cls_t            rsp_class_q;
  logic            rsp_sign_q;
  cls_t            cls;

  // Search for the first valid requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    grant     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == ST_IDLE && any_valid)
      bus.req_ready[grant] = 1'b1;
  end

  hp_classify u_classify (
    .f   (op_q),
    .cls (cls)
  );

  // Operand capture needs no reset: it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && any_valid) begin
      op_q <= bus.req_data[int'(grant)*FP_W +: FP_W];
      id_q <= grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      rsp_id_q    <= '0;
      rsp_class_q <= '0;
      rsp_sign_q  <= 1'b0;
      snan_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          rsp_class_q <= cls;
          rsp_sign_q  <= op_q[SIGN_BIT];
          rsp_id_q    <= id_q;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
            if (rsp_class_q[CLS_SNAN] && !(&snan_cnt))
              snan_cnt <= snan_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_class = rsp_class_q;
  assign bus.rsp_sign  = rsp_sign_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_hp_class_sched.sv
// Bench for hp_class_sched: a cycle model with a scoreboard of expected responses,
// run against a default instance and a CNT_W=2 instance on identical stimulus.
module tb_hp_class_sched;

  localparam int M_IDLE = 0;
  localparam int M_EVAL = 1;
  localparam int M_RESP = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [5:0] cls;
    logic       sgn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy0, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  hp_class_sched_if #(.NREQ(4), .ID_W(2)) i0 ();
  hp_class_sched_if #(.NREQ(4), .ID_W(2)) i1 ();

  assign i1.req_valid = i0.req_valid;
  assign i1.req_data  = i0.req_data;
  assign i1.rsp_ready = i0.rsp_ready;

  hp_class_sched #(.NREQ(4), .ID_W(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(i0), .busy(busy0), .snan_cnt(cnt0)
  );
  hp_class_sched #(.NREQ(4), .ID_W(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(i1), .busy(busy1), .snan_cnt(cnt1)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   mst    = M_IDLE;
  int   mptr   = 0;
  int   mcnt0  = 0;
  int   mcnt1  = 0;
  bit   done   = 0;
  exp_t last;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ref_cls(input logic [15:0] f);
    if (f[14:10] == 5'b11111) begin
      if (f[9:0] == 10'd0) return 6'b001000;
      return f[9] ? 6'b010000 : 6'b100000;
    end
    if (f[14:10] == 5'b00000) return (f[9:0] == 10'd0) ? 6'b000100 : 6'b000010;
    return 6'b000001;
  endfunction

  // Checks the current cycle against the model, then advances the model across the next edge.
  task automatic model_check();
    logic [3:0] exp_rdy;
    logic [7:0] v2;
    logic [15:0] d;
    int g;
    bit found;
    exp_t e;
    exp_rdy = '0;
    chk("rsp_valid", 32'(i0.rsp_valid), 32'(mst == M_RESP));
    chk("busy", 32'(busy0), 32'(mst != M_IDLE));
    chk("busy_b", 32'(busy1), 32'(mst != M_IDLE));
    chk("snan_cnt", 32'(cnt0), 32'(mcnt0));
    chk("snan_cnt_sat", 32'(cnt1), 32'(mcnt1));
    case (mst)
      M_IDLE: begin
        if (|i0.req_valid) begin
          v2 = {i0.req_valid, i0.req_valid} >> mptr;
          found = 0;
          g = 0;
          for (int k = 0; k < 4; k++)
            if (!found && v2[k]) begin found = 1; g = k; end
          g = (g + mptr) % 4;
          exp_rdy[g] = 1'b1;
          d = i0.req_data[16*g +: 16];
          e.id = 2'(g);
          e.cls = ref_cls(d);
          e.sgn = d[15];
          sb.push_back(e);
          mptr = (g + 1) % 4;
          mst = M_EVAL;
        end
      end
      M_EVAL: mst = M_RESP;
      default: begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb[0];
          chk("rsp_id", 32'(i0.rsp_id), 32'(e.id));
          chk("rsp_class", 32'(i0.rsp_class), 32'(e.cls));
          chk("rsp_sign", 32'(i0.rsp_sign), 32'(e.sgn));
          if (i0.rsp_ready) begin
            void'(sb.pop_front());
            last = e;
            done = 1;
            if (e.cls[5]) begin
              if (mcnt0 != 65535) mcnt0++;
              if (mcnt1 != 3) mcnt1++;
            end
            mst = M_IDLE;
          end
        end
      end
    endcase
    chk("req_ready", 32'(i0.req_ready), 32'(exp_rdy));
  endtask

  task automatic step();
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic model_reset();
    mst = M_IDLE; mptr = 0; mcnt0 = 0; mcnt1 = 0;
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(i0.req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(i0.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(i0.rsp_id), 32'd0);
    chk({tag, "_class"}, 32'(i0.rsp_class), 32'd0);
    chk({tag, "_sign"}, 32'(i0.rsp_sign), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt0), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_one(input int id, input logic [15:0] data);
    done = 0;
    i0.req_valid = 4'(1 << id);
    i0.req_data[16*id +: 16] = data;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (mst != M_IDLE) i0.req_valid = '0;
    end
    chk("run_done", 32'(done), 32'd1);
  endtask

  task automatic drain();
    i0.req_valid = '0;
    i0.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (mst != M_IDLE); c++) step();
    chk("drain_idle", 32'(mst), 32'(M_IDLE));
  endtask

  logic [15:0] cov_data [6] = '{16'h3C00, 16'h7C00, 16'h7E00, 16'h7C01, 16'h0001, 16'h8000};
  logic [5:0]  cov_cls  [6] = '{6'b000001, 6'b001000, 6'b010000, 6'b100000, 6'b000010, 6'b000100};
  logic [1:0]  sat_exp  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  int          fair_ids [$];

  initial begin
    i0.req_valid = 4'b1111;
    i0.req_data  = {16'h7C01, 16'h7C01, 16'h7C01, 16'h7C01};
    i0.rsp_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset asserted during EVAL discards the operation.
    i0.req_valid = 4'b0001;
    step();
    i0.req_valid = '0;
    chk("rst_mid_in_eval", 32'(mst), 32'(M_EVAL));
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    #1;
    check_zero_outputs("rst_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) step();
    run_one(2, 16'h3C00);
    chk("rst_first_grant", 32'(last.id), 32'd2);
    chk("rst_cnt_kept", 32'(cnt0), 32'd0);

    // Class coverage on requester 0.
    for (int t = 0; t < 6; t++) begin
      run_one(0, cov_data[t]);
      chk("cls_tbl", 32'(last.cls), 32'(cov_cls[t]));
    end
    step();
    chk("cnt_after_cov", 32'(cnt0), 32'd1);
    chk("sign_8000", 32'(last.sgn), 32'd1);

    // Fairness with all four requesters continuously valid.
    do_reset();
    i0.req_data  = {16'h0400, 16'h0000, 16'hFC00, 16'h3555};
    i0.req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      done = 0;
      step();
      if (done) fair_ids.push_back(int'(last.id));
    end
    drain();
    chk("fair_count", 32'(fair_ids.size()), 32'd5);
    for (int k = 0; k < fair_ids.size() && k < 5; k++)
      chk("fair_order", 32'(fair_ids[k]), 32'(k % 4));

    // Backpressure: hold RESP for five cycles.
    i0.req_valid = 4'b1111;
    i0.rsp_ready = 1'b0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_resp", 32'(mst), 32'(M_RESP));
      step();
    end
    i0.rsp_ready = 1'b1;
    step();
    chk("bp_release_idle", 32'(mst), 32'(M_IDLE));
    #1;
    chk("bp_busy_low", 32'(busy0), 32'd0);
    @(negedge clk);
    mst = M_IDLE;
    sb.delete();
    i0.req_valid = '0;
    // The edge after the idle cycle accepted a new request; let it complete.
    mst = M_EVAL;
    begin
      exp_t e;
      logic [15:0] d;
      d = i0.req_data[16*mptr +: 16];
      e.id = 2'(mptr); e.cls = ref_cls(d); e.sgn = d[15];
      sb.push_back(e);
      mptr = (mptr + 1) % 4;
    end
    drain();

    // Saturation on the CNT_W=2 instance.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      run_one(1, 16'h7D00);
      step();
      chk("sat_cnt", 32'(cnt1), 32'(sat_exp[t]));
    end
    chk("wide_cnt", 32'(cnt0), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_class_sched.md
# hp_class_sched

Shared-classifier scheduler for the half-precision FPU. It arbitrates up to NREQ requesters, each holding one 16-bit binary16 operand, onto a single classification datapath. Requesters are served round-robin, one at a time. Each result is returned as a one-hot class vector tagged with the requester ID. A saturating signalling-NaN event counter feeds FPU exception status.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- ID_W, default 2: requester ID width, equal to clog2(NREQ).
- CNT_W, default 16: width of the sNaN event counter.
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- req_valid, input, NREQ: bit i set when requester i presents an operand.
- req_data, input, 16*NREQ: operand of requester i in bits [16*i+15:16*i].
- req_ready, output, NREQ: at most one bit set; acceptance happens when req_valid[i] & req_ready[i].
- rsp_valid, output, 1: result available.
- rsp_ready, input, 1: consumer accepts the result.
- rsp_id, output, ID_W: index of the requester that owns the result.
- rsp_class, output, 6: one-hot class vector, bits {snan, qnan, infinity, zero, subnormal, normal}, with bit 5 = snan.
- rsp_sign, output, 1: sign bit of the operand.
- busy, output, 1: state is not IDLE.
- snan_cnt, output, CNT_W: count of sNaN results delivered; saturates at all-ones.

## Operation
- Operand fields: sign is f[15], exponent is f[14:10], significand is f[9:0].
- Classification uses all 5 exponent bits. Exactly one class bit is set for every 16-bit input.
  - infinity: exp=11111, sig=0.
  - qnan: exp=11111, f[9]=1.
  - snan: exp=11111, f[9]=0, sig!=0.
  - zero: exp=0, sig=0.
  - subnormal: exp=0, sig!=0.
  - normal: any other exponent.
- FSM states:
  - IDLE: grant = first i with req_valid[i], searching from rr_ptr upward, modulo NREQ. req_ready[grant]=1 only if some req_valid is set. On acceptance: latch the operand into op_q and the grant into id_q, set rr_ptr to grant+1 mod NREQ, go to EVAL. With no request, stay in IDLE.
  - EVAL: classify op_q. Register the class, sign and id_q into the response registers. Go to RESP.
  - RESP: rsp_valid=1. rsp_id, rsp_class and rsp_sign are held stable. When rsp_ready=1: go to IDLE, and increment snan_cnt if rsp_class[5] is set and the counter is not all-ones.
- req_ready is all zero outside IDLE.
- req_ready depends only on req_valid and registered state. It never depends on req_data.
- A requester that drops req_valid before its grant loses its turn. No state is kept for it.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0 while rst is high.
  - rsp_valid=0, rsp_id=0, rsp_class=0, rsp_sign=0, busy=0, snan_cnt=0.
- Latency: acceptance at edge N, then EVAL during cycle N+1, then rsp_valid=1 from cycle N+2.
- Throughput: one operand per 3 cycles when rsp_ready is held high.
- Backpressure: RESP holds indefinitely while rsp_ready=0. No new acceptance happens during that time.
- Simultaneous requests: the rr_ptr search order decides the grant. A requester held continuously valid is served within NREQ grants.
- Reset asserted in EVAL or RESP: the in-flight operation is discarded, with no response and no counter update.
- rsp_class is all-zero only while rsp_valid=0 after reset. Once the first result is loaded it keeps its last value.
- snan_cnt at all-ones stays at all-ones.

## Structure
- Shared package hp_pkg holds:
  - class bit index constants (CLS_SNAN=5 .. CLS_NORMAL=0);
  - the FSM state encoding (IDLE, EVAL, RESP);
  - binary16 field positions.
- Sub-module hp_classify: purely combinational, 16-bit input to 6-bit one-hot output, instantiated once on op_q.
- Top level contains the round-robin arbiter, the FSM, the response registers and the counter.

## Test plan
- Class coverage, requester 0, rsp_ready high:
  - 0x3C00 gives 000001.
  - 0x7C00 gives 001000.
  - 0x7E00 gives 010000.
  - 0x7C01 gives 100000, and snan_cnt becomes 1.
  - 0x0001 gives 000010.
  - 0x8000 gives 000100 with rsp_sign=1.
  - Each rsp_valid appears 2 cycles after acceptance.
- Fairness: after reset, all four req_valid held high. Grants arrive in order 0,1,2,3,0. rsp_id follows the same order. Exactly one req_ready bit is high per IDLE cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. rsp_valid and rsp_id/rsp_class stay constant, req_ready=0, busy=1. Releasing rsp_ready gives IDLE on the next cycle.
- Reset mid-operation: assert rst during EVAL. All outputs go to 0 immediately, there is no response and snan_cnt is unchanged at 0. After release, a request from requester 2 gets the first grant.
- Saturation: CNT_W=2, five sNaN (0x7D00) operands. snan_cnt reads 1,2,3,3,3.
